// File: rtl/stall_fifo_pkg.sv
// stall_fifo_pkg: shared defaults, count typedef and circular pointer increment.
// Used by stall_fifo (enable-gated pipeline receiver with stall feedback).
package stall_fifo_pkg;

  localparam int DEPTH_DEF        = 64;
  localparam int STALL_MARGIN_DEF = 2;
  localparam int PTR_W            = 16;

  typedef logic [$clog2(DEPTH_DEF):0] cnt_t;

  // DEPTH-1 entries is not a power of two, so wrap by compare.
  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] ptr,
    input logic [PTR_W-1:0] last
  );
    return (ptr == last) ? '0 : ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/stall_fifo_sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port, one registered read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (next cycle).
module sdp_ram #(
  parameter int WIDTH   = 64,
  parameter int ENTRIES = 63,
  parameter int AW      = 6
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [ENTRIES];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/stall_fifo.sv
// stall_fifo: FWFT FIFO behind a no-backpressure pipeline, registered stall out.
// Ports: wr_en/wr_data in, rd_valid/rd_ready/rd_data out, stall, count, overflow,
// flush; hwm/stall_cycles only when STALL_FIFO_STATS_EN is defined.
module stall_fifo
  import stall_fifo_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int LAT_W        = 8,
  parameter int STALL_MARGIN = STALL_MARGIN_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [LAT_W-1:0]       pipe_latency,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   stall,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
`ifdef STALL_FIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH):0] hwm,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH - 1);
  localparam int SW = (LAT_W + 2 > CW) ? LAT_W + 2 : CW;

  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 2);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [SW-1:0] DEP_S  = SW'(DEPTH);
  localparam logic [SW-1:0] MARG_S = SW'(STALL_MARGIN);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic             stall_q, stall_d;
  logic             fwd_q, fwd_d;
  logic [WIDTH-1:0] fwd_dat_q, fwd_dat_d;

  logic             ram_we;
  logic [WIDTH-1:0] ram_rdata;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    mem_cnt;
  logic             pop, full, wr_acc;
  logic             mem_ne, load, bypass, mem_wr;

  sdp_ram #(
    .WIDTH  (WIDTH),
    .ENTRIES(DEPTH - 1),
    .AW     (AW)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data),
    .raddr_i(rd_ptr_d),
    .rdata_o(ram_rdata)
  );

  // RAM returns the old word when the head slot was written
  // on the same edge it was read; use the captured write data.
  assign head    = fwd_q ? fwd_dat_q : ram_rdata;
  assign pop     = vld_q & rd_ready;
  assign full    = (cnt_q == FULL);
  assign wr_acc  = wr_en & (~full | pop);
  assign mem_cnt = cnt_q - CW'(vld_q);
  assign mem_ne  = (mem_cnt != '0);
  assign load    = (~vld_q | pop) & (mem_ne | wr_acc);
  assign bypass  = load & ~mem_ne;
  assign mem_wr  = wr_acc & ~bypass;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_we    = mem_wr;
    if (mem_wr)
      wr_ptr_d = AW'(ptr_inc(PTR_W'(wr_ptr_q), PTR_W'(LAST)));
    if (load & mem_ne)
      rd_ptr_d = AW'(ptr_inc(PTR_W'(rd_ptr_q), PTR_W'(LAST)));
    vld_d     = load | (vld_q & ~pop);
    out_d     = load ? (mem_ne ? head : wr_data) : out_q;
    cnt_d     = cnt_q + CW'(wr_acc) - CW'(pop);
    ovf_d     = ovf_q | (wr_en & full & ~pop);
    fwd_d     = mem_wr & (wr_ptr_q == rd_ptr_d);
    fwd_dat_d = wr_data;
    stall_d   = (DEP_S - SW'(cnt_d)) <= (SW'(pipe_latency) + MARG_S);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ram_we   = 1'b0;
      vld_d    = 1'b0;
      out_d    = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      fwd_d    = 1'b0;
      stall_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      vld_q     <= 1'b0;
      ovf_q     <= 1'b0;
      stall_q   <= 1'b0;
      fwd_q     <= 1'b0;
      fwd_dat_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
      ovf_q     <= ovf_d;
      stall_q   <= stall_d;
      fwd_q     <= fwd_d;
      fwd_dat_q <= fwd_dat_d;
    end
  end

  assign stall    = stall_q;
  assign rd_valid = vld_q;
  assign rd_data  = out_q;
  assign count    = cnt_q;
  assign overflow = ovf_q;

`ifdef STALL_FIFO_STATS_EN
  logic [CW-1:0] hwm_q, hwm_d;
  logic [31:0]   sc_q, sc_d;

  always_comb begin
    hwm_d = (cnt_d > hwm_q) ? cnt_d : hwm_q;
    sc_d  = (stall_q & ~&sc_q) ? sc_q + 32'd1 : sc_q;
    if (flush) begin
      hwm_d = '0;
      sc_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
      sc_q  <= '0;
    end else begin
      hwm_q <= hwm_d;
      sc_q  <= sc_d;
    end
  end

  assign hwm          = hwm_q;
  assign stall_cycles = sc_q;
`endif

endmodule

// File: tb/tb_stall_fifo.sv
// tb_stall_fifo: directed vector table plus corner-case sequences for stall_fifo.
// Scoreboarded random traffic through a modelled in-flight delay line.
module tb_stall_fifo;
  import stall_fifo_pkg::*;

  localparam int W  = 64;
  localparam int D  = 64;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [LW-1:0] pipe_latency = 8'd4;
  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          stall;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [W-1:0]  rd_data;
  cnt_t          count;
  logic          overflow;
`ifdef STALL_FIFO_STATS_EN
  cnt_t          hwm;
  logic [31:0]   stall_cycles;
`endif

  int errs = 0;
  int checks = 0;

  stall_fifo #(
    .WIDTH(W), .DEPTH(D), .LAT_W(LW), .STALL_MARGIN(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .pipe_latency(pipe_latency),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .stall       (stall),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .overflow    (overflow)
`ifdef STALL_FIFO_STATS_EN
    ,
    .hwm         (hwm),
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [63:0] d;
    logic        rr;
    logic        fl;
    logic        ev;
    logic [63:0] ed;
    int          ec;
    logic        es;
    logic        eo;
  } vec_t;

  vec_t tv[12];

  logic        pv [64];
  logic [63:0] pd [64];
  logic [63:0] sb [$];
  logic [63:0] nextw;
  logic [63:0] front;
  int          lats [3];
  int          lat;
  logic        rr;

  initial begin
    tv[0]  = '{1'b1, 64'hBEEF_0000_0000_0001, 1'b0, 1'b0,
               1'b1, 64'hBEEF_0000_0000_0001, 1, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 64'd2, 1'b1, 1'b0, 1'b1, 64'd2, 1, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 64'd3, 1'b0, 1'b0, 1'b1, 64'd2, 2, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 64'd4, 1'b0, 1'b0, 1'b1, 64'd2, 3, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd3, 2, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 64'd5, 1'b1, 1'b0, 1'b1, 64'd4, 2, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd5, 1, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 0, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 0, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 64'd6, 1'b0, 1'b1, 1'b0, 64'd0, 0, 1'b0, 1'b0};
    tv[10] = '{1'b1, 64'd7, 1'b0, 1'b0, 1'b1, 64'd7, 1, 1'b0, 1'b0};
    tv[11] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 64'd0, 0, 1'b0, 1'b0};

    // reset state
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_data", rd_data, 64'd0);
    rst_n = 1'b1;
    step();

    // vector table
    for (int i = 0; i < 12; i++) begin
      wr_en    = tv[i].wr;
      wr_data  = tv[i].d;
      rd_ready = tv[i].rr;
      flush    = tv[i].fl;
      step();
      chk($sformatf("v%0d_valid", i), 64'(rd_valid), 64'(tv[i].ev));
      if (tv[i].ev)
        chk($sformatf("v%0d_data", i), rd_data, tv[i].ed);
      chk($sformatf("v%0d_count", i), 64'(count), 64'(tv[i].ec));
      chk($sformatf("v%0d_stall", i), 64'(stall), 64'(tv[i].es));
      chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(tv[i].eo));
    end
    wr_en = 1'b0; rd_ready = 1'b0; flush = 1'b0;

    // stall threshold at lat=4: stall once count >= 64-6
    pipe_latency = 8'd4;
    for (int i = 0; i < 62; i++) begin
      wr_en = 1'b1; wr_data = 64'(i);
      step();
      chk($sformatf("thr_count%0d", i), 64'(count), 64'(i + 1));
      chk($sformatf("thr_stall%0d", i), 64'(stall),
          64'((i + 1) >= 58));
    end
    wr_en = 1'b0;
    step();
    chk("thr_count62", 64'(count), 64'd62);
    chk("thr_ovf", 64'(overflow), 64'd0);

    // fill to full, one lost write
    for (int i = 62; i < 65; i++) begin
      wr_en = 1'b1; wr_data = 64'(i);
      step();
    end
    wr_en = 1'b0;
    chk("full_count", 64'(count), 64'd64);
    chk("full_ovf", 64'(overflow), 64'd1);
`ifdef STALL_FIFO_STATS_EN
    chk("hwm_full", 64'(hwm), 64'd64);
`endif
    rd_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("drain_v%0d", i), 64'(rd_valid), 64'd1);
      chk($sformatf("drain_d%0d", i), rd_data, 64'(i));
      step();
    end
    rd_ready = 1'b0;
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid", 64'(rd_valid), 64'd0);
    chk("drain_ovf", 64'(overflow), 64'd1);

    // full with simultaneous read and write
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; wr_data = 64'(i);
      step();
    end
    chk("ff_count0", 64'(count), 64'd64);
    rd_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      wr_en = 1'b1; wr_data = 64'(64 + k);
      chk($sformatf("ff_d%0d", k), rd_data, 64'(k));
      step();
      chk($sformatf("ff_c%0d", k), 64'(count), 64'd64);
    end
    wr_en = 1'b0; rd_ready = 1'b0;
    chk("ff_ovf", 64'(overflow), 64'd0);

    // random traffic through a modelled delay line
    lats[0] = 1; lats[1] = 8; lats[2] = 32;
    for (int li = 0; li < 3; li++) begin
      lat = lats[li];
      flush = 1'b1;
      step();
      flush = 1'b0;
      pipe_latency = LW'(lat);
      sb.delete();
      nextw = 64'(li) << 32;
      for (int i = 0; i < 64; i++) begin
        pv[i] = 1'b0; pd[i] = '0;
      end
      for (int cyc = 0; cyc < 3300; cyc++) begin
        rr = (cyc >= 3100) ? 1'b1 : ($urandom_range(2) != 0);
        rd_ready = rr;
        if (rd_valid && rr) begin
          if (sb.size() == 0) begin
            chk("rand_spurious", 64'(rd_valid), 64'd0);
          end else begin
            front = sb.pop_front();
            chk("rand_data", rd_data, front);
          end
        end
        wr_en = pv[lat-1];
        wr_data = pd[lat-1];
        if (wr_en) sb.push_back(wr_data);
        for (int j = lat - 1; j > 0; j--) begin
          pv[j] = pv[j-1]; pd[j] = pd[j-1];
        end
        pv[0] = !stall && (cyc < 3100) && ($urandom_range(3) != 0);
        pd[0] = nextw;
        if (pv[0]) nextw = nextw + 64'd1;
        step();
      end
      wr_en = 1'b0; rd_ready = 1'b0;
      chk($sformatf("rand_left_l%0d", lat), 64'(sb.size()), 64'd0);
      chk($sformatf("rand_cnt_l%0d", lat), 64'(count), 64'd0);
      chk($sformatf("rand_ovf_l%0d", lat), 64'(overflow), 64'd0);
    end
    pipe_latency = 8'd4;

    // flush then async reset mid-stream
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 64'(100 + i);
      step();
    end
    wr_en = 1'b0;
    chk("mid_count10", 64'(count), 64'd10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("mid_fl_count", 64'(count), 64'd0);
    chk("mid_fl_valid", 64'(rd_valid), 64'd0);
    wr_en = 1'b1; wr_data = 64'hAA;
    step();
    wr_en = 1'b0;
    chk("mid_fl_v", 64'(rd_valid), 64'd1);
    chk("mid_fl_d", rd_data, 64'hAA);
    chk("mid_fl_c", 64'(count), 64'd1);
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 64'(200 + i);
      step();
    end
    wr_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_data", rd_data, 64'd0);
    #2 rst_n = 1'b1;
    step();
    wr_en = 1'b1; wr_data = 64'hBB;
    step();
    wr_en = 1'b0;
    chk("mid_rst_v", 64'(rd_valid), 64'd1);
    chk("mid_rst_d", rd_data, 64'hBB);
    chk("mid_rst_c", 64'(count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
